fifo_input_ctrl: RTL and testbench
==================================

# fifo_input_ctrl

Upstream request generator for the FIFO stage. Debounces the write and read push-buttons, converts each confirmed press into a single-cycle `wReq`/`rReq` pulse, and captures the switch word onto `din` in the same cycle as `wReq`. Requests are gated by the FIFO's `full`/`empty` flags; suppressed requests are reported on `blocked`.

## Interface
- `WL`, 10: data width, equal to the FIFO's `WL`.
- `DEB_CYCLES`, 500_000: cycles a button level must stay stable to be accepted (10 ms at 50 MHz); minimum 2.
- `REPEAT_CYCLES`, 25_000_000: auto-repeat period while held; used only with `FIFO_AUTO_REPEAT_EN`; minimum 2.
- `CLK` input 1: clock; all state changes on the rising edge.
- `RST` input 1: asynchronous, active-low reset.
- `btnW` input 1: raw write button, asynchronous, active-high.
- `btnR` input 1: raw read button, asynchronous, active-high.
- `sw` input WL: raw switch word, quasi-static.
- `full` input 1: FIFO full flag, synchronous to `CLK`.
- `empty` input 1: FIFO empty flag, synchronous to `CLK`.
- `wReq` output 1: one-cycle write request to the FIFO.
- `rReq` output 1: one-cycle read request to the FIFO.
- `din` output WL: write data; valid while `wReq` is 1 and held until the next write pulse.
- `blocked` output 1: one-cycle pulse when a request is suppressed by `full` or `empty`.

## Operation
- `btnW` and `btnR` each pass through a 2-flop synchronizer. The synchronized level `s` drives an independent debounce FSM per button.
- Debounce FSM states and transitions:
  - IDLE: when `s`=1, clear the counter and go to CONF_P.
  - CONF_P: if `s`=0, go to IDLE. Otherwise count; when the count reaches DEB_CYCLES-1, go to HELD and raise the press event.
  - HELD: when `s`=0, clear the counter and go to CONF_R.
  - CONF_R: if `s`=1, go to HELD with no new event. Otherwise count; at DEB_CYCLES-1, go to IDLE.
- A glitch shorter than DEB_CYCLES never produces an event.
- Write event:
  - if `full`=0: `wReq`=1 for one cycle and `din`<=`sw` (registered in the same edge).
  - if `full`=1: `wReq` stays 0, `din` is unchanged, `blocked`=1.
- Read event:
  - if `empty`=0: `rReq`=1 for one cycle.
  - if `empty`=1: `rReq` stays 0, `blocked`=1.
- Write and read events in the same cycle: both are evaluated independently, so `wReq` and `rReq` may both be 1. `blocked`=1 if either is suppressed.
- The flags are sampled in the same cycle the event is raised. No request is queued or retried.

## Timing
- Reset values: `wReq`=0, `rReq`=0, `blocked`=0, `din`=0, both FSMs in IDLE, all counters 0, synchronizers 0. Outputs clear immediately on `RST` falling, without waiting for a clock edge.
- Press latency: the request pulse is registered on the edge DEB_CYCLES+3 cycles after the raw edge, counted from the first `CLK` edge that sees the raw level.
- Minimum spacing between two presses: 2·DEB_CYCLES+6 cycles.
- All outputs are registered; there is no combinational path from inputs to outputs.
- Reset asserted mid-debounce or mid-HELD: the block returns to IDLE. A button still held at reset release is treated as a new press and yields one event after the full press latency.
- Counter width is `$clog2` of max(DEB_CYCLES, REPEAT_CYCLES); counters saturate and never wrap.

## Configuration
- `FIFO_AUTO_REPEAT_EN` defined:
  - in HELD, a repeat counter runs; every REPEAT_CYCLES cycles it raises a further event for that button;
  - each repeated event is gated identically to a press;
  - the repeat counter clears on entry to HELD and on each repeated event.
- `FIFO_AUTO_REPEAT_EN` undefined: exactly one event per press, and the repeat logic is absent.

## Structure
- Shared package `fifo_pkg` holds:
  - the debounce state typedef (IDLE, CONF_P, HELD, CONF_R);
  - default constants `FIFO_WL`, `FIFO_DEB_CYCLES` and `FIFO_REPEAT_CYCLES`.
- Sub-module `btn_debounce`: synchronizer, FSM, counter, and optional repeat logic. Output is a one-cycle `evt`. It is instantiated twice. The top level holds the gating logic, the `din` register and the output registers.

## Test plan
Run with DEB_CYCLES=4 and REPEAT_CYCLES=8.
- Clean `btnW` press, `sw`=10'h2A5, `full`=0 -> single `wReq` pulse 7 cycles after the edge, `din`=10'h2A5 in the same cycle, `blocked`=0.
- `btnR` glitch of 2 cycles -> no `rReq` and no `blocked`. A 6-cycle press with `empty`=0 -> exactly one `rReq`.
- Press `btnW` with `full`=1 -> `wReq`=0, `din` keeps its previous value, `blocked`=1 for one cycle. Press `btnR` with `empty`=1 -> `rReq`=0, `blocked`=1.
- `btnW` and `btnR` raised on the same edge, `full`=0, `empty`=0 -> `wReq` and `rReq` both 1 in the same single cycle.
- `RST` pulled low while in CONF_P with the button held -> outputs 0 immediately. After release, one `wReq` 7 cycles later.
- With `FIFO_AUTO_REPEAT_EN`, hold `btnW` for 30 cycles after the first pulse -> additional `wReq` pulses every 8 cycles (3 extra). Without the macro, none.

Source files
------------

// File: rtl/fifo_pkg.sv
// fifo_pkg: constants and types shared by the FIFO input-control blocks.
//   FIFO_WL            default data width
//   FIFO_DEB_CYCLES    default debounce window (10 ms at 50 MHz)
//   FIFO_REPEAT_CYCLES default auto-repeat period (0.5 s at 50 MHz)
//   deb_state_t        debounce FSM state encoding
//   cnt_width()        counter width sized for the larger of two periods
package fifo_pkg;

  localparam int FIFO_WL            = 10;
  localparam int FIFO_DEB_CYCLES    = 500_000;
  localparam int FIFO_REPEAT_CYCLES = 25_000_000;

  // Plain-vector states keep the encoding visible in waveforms and
  // compatible with older tools that handle enums poorly.
  typedef logic [1:0] deb_state_t;
  localparam deb_state_t ST_IDLE   = 2'd0;  // released, waiting for a press
  localparam deb_state_t ST_CONF_P = 2'd1;  // confirming a press
  localparam deb_state_t ST_HELD   = 2'd2;  // press accepted, button down
  localparam deb_state_t ST_CONF_R = 2'd3;  // confirming a release

  // Width that holds every value 0 .. max(a, b)-1, never less than 1.
  function automatic int cnt_width(input int a, input int b);
    int m;
    m = (a > b) ? a : b;
    return ($clog2(m) < 1) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/fifo_input_ctrl_btn_debounce.sv
// btn_debounce: synchronizes and debounces one raw push-button and emits a
// one-cycle evt for every confirmed press.
//   clk, rst_n  clock, asynchronous active-low reset
//   btn         raw asynchronous button level, active-high
//   evt         one-cycle press event (registered)
// Optional feature: FIFO_AUTO_REPEAT_EN adds a further evt every
// REPEAT_CYCLES cycles while the button stays held.
module btn_debounce
  import fifo_pkg::*;
#(
  parameter int DEB_CYCLES    = FIFO_DEB_CYCLES,
  parameter int REPEAT_CYCLES = FIFO_REPEAT_CYCLES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  output logic evt
);

  localparam int CW = cnt_width(DEB_CYCLES, REPEAT_CYCLES);
  localparam logic [CW-1:0] DEB_LAST = CW'(DEB_CYCLES - 1);

  logic [1:0]    sync;
  logic          s;
  deb_state_t    state;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_inc;

  assign s = sync[1];
  // Counters saturate at all-ones instead of wrapping.
  assign cnt_inc = (cnt == '1) ? cnt : cnt + 1'b1;

`ifdef FIFO_AUTO_REPEAT_EN
  localparam logic [CW-1:0] REP_LAST = CW'(REPEAT_CYCLES - 1);
  logic [CW-1:0] rcnt;
  logic [CW-1:0] rcnt_inc;
  assign rcnt_inc = (rcnt == '1) ? rcnt : rcnt + 1'b1;
`endif

  // NOTE: the reset branch must cover every register in the block; anything
  // missing from it turns into a flop with a mux on the reset path instead.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync  <= '0;
      state <= ST_IDLE;
      cnt   <= '0;
      evt   <= 1'b0;
`ifdef FIFO_AUTO_REPEAT_EN
      rcnt  <= '0;
`endif
    end else begin
      // NOTE: non-blocking assignments here so every flop samples the
      // pre-edge values, e.g. the second sync stage gets the old first stage.
      sync <= {sync[0], btn};
      evt  <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (s) begin
            cnt   <= '0;
            state <= ST_CONF_P;
          end
        end
        ST_CONF_P: begin
          if (!s) begin
            state <= ST_IDLE;
          end else begin
            // The entry cycle counts as the first stable sample, so the
            // press is accepted on the DEB_CYCLES-th consecutive high sample.
            cnt <= cnt_inc;
            if (cnt_inc == DEB_LAST) begin
              state <= ST_HELD;
              evt   <= 1'b1;
`ifdef FIFO_AUTO_REPEAT_EN
              rcnt  <= '0;
`endif
            end
          end
        end
        ST_HELD: begin
          if (!s) begin
            cnt   <= '0;
            state <= ST_CONF_R;
          end
`ifdef FIFO_AUTO_REPEAT_EN
          else if (rcnt == REP_LAST) begin
            evt  <= 1'b1;
            rcnt <= '0;
          end else begin
            rcnt <= rcnt_inc;
          end
`endif
        end
        ST_CONF_R: begin
          if (s) begin
            // Bounce during release: back to HELD without a new event.
            state <= ST_HELD;
`ifdef FIFO_AUTO_REPEAT_EN
            rcnt  <= '0;
`endif
          end else begin
            cnt <= cnt_inc;
            if (cnt_inc == DEB_LAST) state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/fifo_input_ctrl.sv
// fifo_input_ctrl: turns debounced write/read button presses into one-cycle
// FIFO requests, capturing the switch word as write data.
//   CLK, RST   clock, asynchronous active-low reset
//   btnW, btnR raw write/read buttons, asynchronous, active-high
//   sw         switch word, captured into din on each issued write
//   full/empty FIFO flags, gate write/read requests
//   wReq/rReq  one-cycle write/read requests
//   din        write data, held until the next issued write
//   blocked    one-cycle pulse when a request was suppressed by a flag
// Optional feature: define FIFO_AUTO_REPEAT_EN for auto-repeat while held.
module fifo_input_ctrl
  import fifo_pkg::*;
#(
  parameter int WL            = FIFO_WL,
  parameter int DEB_CYCLES    = FIFO_DEB_CYCLES,
  parameter int REPEAT_CYCLES = FIFO_REPEAT_CYCLES
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          btnW,
  input  logic          btnR,
  input  logic [WL-1:0] sw,
  input  logic          full,
  input  logic          empty,
  output logic          wReq,
  output logic          rReq,
  output logic [WL-1:0] din,
  output logic          blocked
);

  logic evt_w;
  logic evt_r;
  logic w_ok;
  logic r_ok;

  btn_debounce #(
    .DEB_CYCLES   (DEB_CYCLES),
    .REPEAT_CYCLES(REPEAT_CYCLES)
  ) u_deb_w (
    .clk  (CLK),
    .rst_n(RST),
    .btn  (btnW),
    .evt  (evt_w)
  );

  btn_debounce #(
    .DEB_CYCLES   (DEB_CYCLES),
    .REPEAT_CYCLES(REPEAT_CYCLES)
  ) u_deb_r (
    .clk  (CLK),
    .rst_n(RST),
    .btn  (btnR),
    .evt  (evt_r)
  );

  // Flags are sampled in the cycle the event is presented; nothing is queued.
  assign w_ok = evt_w & ~full;
  assign r_ok = evt_r & ~empty;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      wReq    <= 1'b0;
      rReq    <= 1'b0;
      blocked <= 1'b0;
      din     <= '0;
    end else begin
      wReq    <= w_ok;
      rReq    <= r_ok;
      blocked <= (evt_w & full) | (evt_r & empty);
      if (w_ok) din <= sw;
    end
  end

endmodule

// File: tb/tb_fifo_input_ctrl.sv
// Testbench for fifo_input_ctrl with DEB_CYCLES=4, REPEAT_CYCLES=8.
// A behavioural model derives the expected outputs from the raw button
// history: a level is accepted once the 2-cycle-delayed button has differed
// from the accepted level for DEB samples in a row; each accepted press (and,
// with FIFO_AUTO_REPEAT_EN, every REPEAT held samples) yields one event that
// is gated by the flags one cycle later.
module tb_fifo_input_ctrl;

  localparam int WL  = 10;
  localparam int DEB = 4;
  localparam int REP = 8;

  logic          clk;
  logic          rst_n;
  logic          btn_w;
  logic          btn_r;
  logic [WL-1:0] sw;
  logic          full;
  logic          empty;
  logic          w_req;
  logic          r_req;
  logic [WL-1:0] din;
  logic          blocked;

  fifo_input_ctrl #(
    .WL           (WL),
    .DEB_CYCLES   (DEB),
    .REPEAT_CYCLES(REP)
  ) dut (
    .CLK    (clk),
    .RST    (rst_n),
    .btnW   (btn_w),
    .btnR   (btn_r),
    .sw     (sw),
    .full   (full),
    .empty  (empty),
    .wReq   (w_req),
    .rReq   (r_req),
    .din    (din),
    .blocked(blocked)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests  = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit          dly1[2], dly2[2], db[2], prev_s[2], pend[2];
  int          run[2], rep[2];
  bit          exp_wreq, exp_rreq, exp_blk;
  logic [WL-1:0] exp_din;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int b = 0; b < 2; b++) begin
        dly1[b] = 0; dly2[b] = 0; db[b] = 0; prev_s[b] = 0; pend[b] = 0;
        run[b] = 0; rep[b] = 0;
      end
      exp_wreq = 0; exp_rreq = 0; exp_blk = 0; exp_din = '0;
    end else begin
      bit raw[2];
      raw[0] = btn_w;
      raw[1] = btn_r;
      exp_wreq = pend[0] && !full;
      exp_rreq = pend[1] && !empty;
      exp_blk  = (pend[0] && full) || (pend[1] && empty);
      if (exp_wreq) exp_din = sw;
      for (int b = 0; b < 2; b++) begin
        bit s, ev, flipped;
        s = dly2[b];
        dly2[b] = dly1[b];
        dly1[b] = raw[b];
        ev = 0;
        flipped = 0;
        if (s != db[b]) begin
          run[b]++;
          if (run[b] == DEB) begin
            db[b] = s;
            run[b] = 0;
            flipped = 1;
            if (s) begin
              ev = 1;
              rep[b] = 0;
            end
          end
        end else begin
          run[b] = 0;
        end
`ifdef FIFO_AUTO_REPEAT_EN
        if (db[b] && s && !flipped) begin
          if (prev_s[b]) begin
            rep[b]++;
            if (rep[b] == REP) begin
              ev = 1;
              rep[b] = 0;
            end
          end else begin
            rep[b] = 0;
          end
        end
`endif
        prev_s[b] = s;
        pend[b] = ev;
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  bit started = 0;
  int w_pulses = 0, r_pulses = 0, b_pulses = 0;

  always @(negedge clk) begin
    if (started && rst_n) begin
      check("wreq_model", w_req, exp_wreq);
      check("rreq_model", r_req, exp_rreq);
      check("blocked_model", blocked, exp_blk);
      check("din_model", din, exp_din);
      if (w_req) w_pulses++;
      if (r_req) r_pulses++;
      if (blocked) b_pulses++;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    int wb;
    rst_n = 1'b1; btn_w = 0; btn_r = 0; sw = '0; full = 0; empty = 0;
    #3 rst_n = 1'b0;
    #1;
    check("reset_wreq", w_req, 0);
    check("reset_rreq", r_req, 0);
    check("reset_blocked", blocked, 0);
    check("reset_din", din, 0);
    tick(3);
    rst_n = 1'b1;
    started = 1;
    tick(2);

    // Clean write press: pulse on the 7th edge with din captured.
    sw = 10'h2A5;
    btn_w = 1;
    repeat (6) @(posedge clk);
    #1 check("press_w_early", w_req, 0);
    @(posedge clk);
    #1;
    check("press_w_pulse", w_req, 1);
    check("press_w_din", din, 10'h2A5);
    check("press_w_blocked", blocked, 0);
    btn_w = 0;
    @(posedge clk);
    #1 check("press_w_single", w_req, 0);
    tick(20);
    check("press_w_count", w_pulses, 1);

    // Read glitch of 2 cycles: nothing.
    btn_r = 1; tick(2); btn_r = 0; tick(15);
    check("glitch_r_count", r_pulses, 0);
    check("glitch_blk_count", b_pulses, 0);
    // 6-cycle read press: exactly one rReq.
    btn_r = 1; tick(6); btn_r = 0; tick(20);
    check("press_r_count", r_pulses, 1);

    // Write while full: suppressed, din kept.
    full = 1; sw = 10'h3FF;
    btn_w = 1; tick(8); btn_w = 0; tick(20);
    check("full_w_count", w_pulses, 1);
    check("full_din_kept", din, 10'h2A5);
    check("full_blk_count", b_pulses, 1);
    full = 0;
    // Read while empty: suppressed.
    empty = 1;
    btn_r = 1; tick(8); btn_r = 0; tick(20);
    check("empty_r_count", r_pulses, 1);
    check("empty_blk_count", b_pulses, 2);
    empty = 0;

    // Simultaneous presses: both requests in the same cycle.
    sw = 10'h155;
    btn_w = 1; btn_r = 1;
    repeat (7) @(posedge clk);
    #1;
    check("both_wreq", w_req, 1);
    check("both_rreq", r_req, 1);
    check("both_din", din, 10'h155);
    btn_w = 0; btn_r = 0;
    tick(20);

    // Reset while confirming a press; button still held at release.
    sw = 10'h0AB;
    btn_w = 1;
    tick(4);
    rst_n = 0;
    #1;
    check("midrst_wreq", w_req, 0);
    check("midrst_din", din, 0);
    check("midrst_blocked", blocked, 0);
    tick(2);
    rst_n = 1;
    wb = w_pulses;
    repeat (6) @(posedge clk);
    #1 check("postrst_early", w_req, 0);
    @(posedge clk);
    #1;
    check("postrst_wreq", w_req, 1);
    check("postrst_din", din, 10'h0AB);
    btn_w = 0;
    tick(20);
    check("postrst_count", w_pulses - wb, 1);

    // Long hold: auto-repeat adds 3 pulses when enabled.
    sw = 10'h111;
    wb = w_pulses;
    btn_w = 1; tick(32); btn_w = 0; tick(25);
`ifdef FIFO_AUTO_REPEAT_EN
    check("hold_w_count", w_pulses - wb, 4);
`else
    check("hold_w_count", w_pulses - wb, 1);
`endif
    check("hold_din", din, 10'h111);

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
